// File: rtl/calc_pkg.sv
// Shared opcode, width and sequencer state definitions for the calculator.
package calc_pkg;

  localparam int FUNC_W = 3;

  localparam logic [FUNC_W-1:0] OP_CLR = 3'd0;
  localparam logic [FUNC_W-1:0] OP_LD1 = 3'd1;
  localparam logic [FUNC_W-1:0] OP_LD2 = 3'd2;
  localparam logic [FUNC_W-1:0] OP_LD3 = 3'd3;
  localparam logic [FUNC_W-1:0] OP_DIV = 3'd4;
  localparam logic [FUNC_W-1:0] OP_RES = 3'd5;
  localparam logic [FUNC_W-1:0] OP_DIS = 3'd6;
  localparam logic [FUNC_W-1:0] OP_HLT = 3'd7;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

endpackage

// File: rtl/program_rom.sv
// Fixed division program; every address past the HLT slot also reads HLT/0.
module program_rom
  import calc_pkg::*;
#(
  parameter int VALUE_W = 4,
  parameter int A       = 4,
  parameter int B       = 2,
  parameter int PC_W    = 3
) (
  input  logic [PC_W-1:0]    addr,
  output logic [FUNC_W-1:0]  func,
  output logic [VALUE_W-1:0] value
);

  logic [31:0] addr_ext;

  assign addr_ext = 32'(addr);

  always_comb begin
    func  = OP_HLT;
    value = '0;
    case (addr_ext)
      32'd0: func = OP_CLR;
      32'd1: begin
        func  = OP_LD1;
        value = VALUE_W'(A);
      end
      32'd2: begin
        func  = OP_LD2;
        value = VALUE_W'(B);
      end
      32'd3: func = OP_LD3;
      32'd4: func = OP_DIV;
      32'd5: func = OP_RES;
      32'd6: func = OP_DIS;
      default: func = OP_HLT;
    endcase
  end

endmodule

// File: rtl/program_sequencer.sv
// Steps the program ROM and issues each instruction to the datapath over valid/ready.
module program_sequencer
  import calc_pkg::*;
#(
  parameter int VALUE_W = 4,
  parameter int A       = 4,
  parameter int B       = 2,
  parameter int PC_W    = 3,
  parameter bit LOOP    = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               ready,
  output logic               valid,
  output logic [FUNC_W-1:0]  func,
  output logic [VALUE_W-1:0] value,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic               done
);

  if (A >= (1 << VALUE_W)) begin : g_a_range
    $error("program_sequencer: A does not fit in VALUE_W bits");
  end
  if (B >= (1 << VALUE_W)) begin : g_b_range
    $error("program_sequencer: B does not fit in VALUE_W bits");
  end

  localparam logic [PC_W-1:0] PC_LAST = '1;

  logic [1:0]         state_reg, state_next;
  logic [PC_W-1:0]    pc_reg, pc_next;
  logic               valid_reg, valid_next;
  logic [FUNC_W-1:0]  func_reg, func_next;
  logic [VALUE_W-1:0] value_reg, value_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;

  logic [PC_W-1:0]    rom_addr;
  logic [FUNC_W-1:0]  rom_func;
  logic [VALUE_W-1:0] rom_value;
  logic               last_instr;

  // Outside ISSUE the only instruction ever needed is the first one.
  assign rom_addr = (state_reg == S_ISSUE) ? pc_reg + PC_W'(1) : '0;

  program_rom #(
    .VALUE_W(VALUE_W),
    .A      (A),
    .B      (B),
    .PC_W   (PC_W)
  ) u_rom (
    .addr (rom_addr),
    .func (rom_func),
    .value(rom_value)
  );

  assign last_instr = (pc_reg == PC_LAST) || (rom_func == OP_HLT);

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    valid_next = valid_reg;
    func_next  = func_reg;
    value_next = value_reg;
    done_next  = 1'b0;
    if (abort) begin
      state_next = S_IDLE;
      pc_next    = '0;
      valid_next = 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_next = S_ISSUE;
            pc_next    = '0;
            valid_next = 1'b1;
            func_next  = rom_func;
            value_next = rom_value;
          end
        end
        S_ISSUE: begin
          if (ready) begin
            pc_next = rom_addr;
            if (last_instr) begin
              // HLT is never presented; pc is left pointing at it.
              state_next = S_DONE;
              valid_next = 1'b0;
              done_next  = 1'b1;
            end else begin
              func_next  = rom_func;
              value_next = rom_value;
            end
          end
        end
        S_DONE: begin
          if (LOOP) begin
            state_next = S_ISSUE;
            pc_next    = '0;
            valid_next = 1'b1;
            func_next  = rom_func;
            value_next = rom_value;
          end else begin
            state_next = S_IDLE;
            pc_next    = '0;
          end
        end
        default: begin
          state_next = S_IDLE;
          pc_next    = '0;
          valid_next = 1'b0;
        end
      endcase
    end
    busy_next = (state_next == S_ISSUE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      pc_reg    <= '0;
      valid_reg <= 1'b0;
      func_reg  <= OP_CLR;
      value_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      valid_reg <= valid_next;
      func_reg  <= func_next;
      value_reg <= value_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign valid = valid_reg;
  assign func  = func_reg;
  assign value = value_reg;
  assign pc    = pc_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: three configurations driven in lockstep against a program-level model.
module tb_program_sequencer;

  logic clk, rst, start, abort, ready;

  logic       valid0, busy0, done0;
  logic [2:0] func0, pc0;
  logic [3:0] value0;
  logic       valid1, busy1, done1;
  logic [2:0] func1, pc1;
  logic [3:0] value1;
  logic       valid2, busy2, done2;
  logic [2:0] func2;
  logic [3:0] pc2;
  logic [7:0] value2;

  program_sequencer u_def (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ready(ready),
    .valid(valid0), .func(func0), .value(value0), .pc(pc0), .busy(busy0), .done(done0)
  );

  program_sequencer #(.LOOP(1'b1)) u_loop (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ready(ready),
    .valid(valid1), .func(func1), .value(value1), .pc(pc1), .busy(busy1), .done(done1)
  );

  program_sequencer #(.VALUE_W(8), .A(200), .B(13), .PC_W(4)) u_wide (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ready(ready),
    .valid(valid2), .func(func2), .value(value2), .pc(pc2), .busy(busy2), .done(done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // Model: the program is the list of instructions before the first HLT;
  // mode 0=idle, 1=presenting prog[idx], 2=done pulse.
  int n_prog[3], depth[3];
  bit loop_cfg[3];
  int pf[3][16], pv[3][16];
  int m_mode[3], m_idx[3], m_func[3], m_val[3];

  task automatic setup_prog(input int d, input int vw, input int a, input int b, input int pcw, input bit lp);
    int vals[7];
    vals = '{0, a, b, 0, 0, 0, 0};
    depth[d] = 1 << pcw;
    n_prog[d] = (depth[d] < 7) ? depth[d] : 7;
    loop_cfg[d] = lp;
    for (int i = 0; i < 7; i++) begin
      pf[d][i] = i;
      pv[d][i] = vals[i] % (1 << vw);
    end
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        m_mode[d] = 0; m_idx[d] = 0; m_func[d] = 0; m_val[d] = 0;
      end else if (abort) begin
        m_mode[d] = 0; m_idx[d] = 0;
      end else if (m_mode[d] == 0) begin
        if (start) begin
          m_mode[d] = 1; m_idx[d] = 0; m_func[d] = pf[d][0]; m_val[d] = pv[d][0];
        end
      end else if (m_mode[d] == 1) begin
        if (ready) begin
          if (d == 0)
            $display("xfer dut0 pc=%0d func=%0d value=%0d", m_idx[d], m_func[d], m_val[d]);
          if (m_idx[d] + 1 < n_prog[d]) begin
            m_idx[d] = m_idx[d] + 1;
            m_func[d] = pf[d][m_idx[d]];
            m_val[d] = pv[d][m_idx[d]];
          end else begin
            m_mode[d] = 2;
            m_idx[d] = (m_idx[d] + 1) % depth[d];
          end
        end
      end else begin
        if (loop_cfg[d]) begin
          m_mode[d] = 1; m_idx[d] = 0; m_func[d] = pf[d][0]; m_val[d] = pv[d][0];
        end else begin
          m_mode[d] = 0; m_idx[d] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      for (int d = 0; d < 3; d++) begin
        int av, ab, ad, af, aval, apc;
        int ev, eb, ed;
        case (d)
          0: begin av = int'(valid0); ab = int'(busy0); ad = int'(done0); af = int'(func0); aval = int'(value0); apc = int'(pc0); end
          1: begin av = int'(valid1); ab = int'(busy1); ad = int'(done1); af = int'(func1); aval = int'(value1); apc = int'(pc1); end
          default: begin av = int'(valid2); ab = int'(busy2); ad = int'(done2); af = int'(func2); aval = int'(value2); apc = int'(pc2); end
        endcase
        ev = (m_mode[d] == 1) ? 1 : 0;
        eb = ev;
        ed = (m_mode[d] == 2) ? 1 : 0;
        checks++;
        if (av !== ev || ab !== eb || ad !== ed || af !== m_func[d] || aval !== m_val[d] || apc !== m_idx[d]) begin
          failures++;
          $display("FAIL model_cmp dut%0d t=%0t got valid=%0d busy=%0d done=%0d func=%0d value=%0d pc=%0d want valid=%0d busy=%0d done=%0d func=%0d value=%0d pc=%0d",
                   d, $time, av, ab, ad, af, aval, apc, ev, eb, ed, m_func[d], m_val[d], m_idx[d]);
        end
      end
    end
  end

  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  initial begin
    int tab_def[7];
    int tab_wide[7];
    int ndone;
    tab_def  = '{0, 4, 2, 0, 0, 0, 0};
    tab_wide = '{0, 200, 13, 0, 0, 0, 0};
    setup_prog(0, 4, 4, 2, 3, 1'b0);
    setup_prog(1, 4, 4, 2, 3, 1'b1);
    setup_prog(2, 8, 200, 13, 4, 1'b0);
    rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0;
    @(negedge clk);
    check_en = 1'b1;
    lit("reset_valid", int'(valid0), 0);
    lit("reset_func", int'(func0), 0);
    lit("reset_pc", int'(pc0), 0);
    lit("reset_busy_done", int'(busy0) + int'(done0), 0);

    // Full program run with ready held high.
    rst = 1'b0; ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      lit("seq_valid", int'(valid0), 1);
      lit("seq_pc", int'(pc0), i);
      lit("seq_func", int'(func0), i);
      lit("seq_value", int'(value0), tab_def[i]);
      lit("wide_value", int'(value2), tab_wide[i]);
      @(negedge clk);
    end
    lit("end_done", int'(done0), 1);
    lit("end_valid", int'(valid0), 0);
    lit("end_pc_hlt", int'(pc0), 7);
    lit("wide_pc_hlt", int'(pc2), 7);
    @(negedge clk);
    lit("after_done", int'(done0), 0);
    lit("after_busy", int'(busy0), 0);
    lit("loop_restart_valid", int'(valid1), 1);
    lit("loop_restart_pc", int'(pc1), 0);

    // Backpressure at pc=2.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    lit("bp_pc_enter", int'(pc0), 2);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      lit("bp_pc", int'(pc0), 2);
      lit("bp_func", int'(func0), 2);
      lit("bp_value", int'(value0), 2);
    end
    ready = 1'b1;
    @(negedge clk);
    lit("bp_release_pc", int'(pc0), 3);

    // Abort at pc=4.
    @(negedge clk);
    lit("abort_at_pc", int'(pc0), 4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    lit("abort_valid", int'(valid0), 0);
    lit("abort_busy", int'(busy0), 0);
    lit("abort_pc", int'(pc0), 0);
    @(negedge clk);
    lit("abort_no_done", int'(done0), 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lit("replay_func", int'(func0), 0);
    lit("replay_valid", int'(valid0), 1);

    // start together with abort from IDLE.
    abort = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    lit("start_abort_valid", int'(valid0), 0);
    lit("start_abort_busy", int'(busy0), 0);

    // start while busy at pc=3 is ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    lit("busy_start_pc3", int'(pc0), 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lit("busy_start_pc", int'(pc0), 4);
    lit("busy_start_func", int'(func0), 4);

    // Three consecutive loops on the LOOP instance.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 24; i++) begin
      if (done1) ndone++;
      @(negedge clk);
    end
    lit("loop_done_count", ndone, 3);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 5) == 0);
      abort = ($urandom_range(0, 24) == 0);
      rst   = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
